// File: rtl/load_store_unit_pkg.sv
// Shared constants, types and decode helpers for the load/store unit.
package load_store_unit_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 10;
  localparam int unsigned MEM_DATA_WIDTH = 32;
  localparam int unsigned XLEN           = 32;

  // RV32 funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_MERGE  = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Access size from funct3 low bits (bit 2 only selects zero-extension)
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  // Encodings with no defined load/store meaning
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return (f3 != F3_SB) && (f3 != F3_SH) && (f3 != F3_SW);
    return (f3 != F3_LB) && (f3 != F3_LH) && (f3 != F3_LW) &&
           (f3 != F3_LBU) && (f3 != F3_LHU);
  endfunction

  // Halfwords need even addresses, words need 4-byte alignment
  function automatic logic f3_misaligned(input lsu_size_t sz, input logic [1:0] lane);
    case (sz)
      SZ_H:    return lane[0];
      SZ_W:    return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane logic: load extract/extend and store read-modify-write merge.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  lsu_size_t                  size_i,
  input  logic                       unsigned_i,
  input  logic [1:0]                 lane_i,
  input  logic [MEM_DATA_WIDTH-1:0]  rdata_i,
  input  logic [MEM_DATA_WIDTH-1:0]  wdata_i,
  input  logic [MEM_DATA_WIDTH-1:0]  old_i,
  output logic [MEM_DATA_WIDTH-1:0]  load_data_c,
  output logic [MEM_DATA_WIDTH-1:0]  merge_data_c
);

  logic [4:0]                shamt;
  logic [MEM_DATA_WIDTH-1:0] lane_data;
  logic [MEM_DATA_WIDTH-1:0] mask;

  // Shift the addressed lane down for loads; build a lane mask for stores
  always_comb begin
    shamt       = {lane_i, 3'b000};
    lane_data   = rdata_i >> shamt;
    load_data_c = lane_data;
    mask        = '1;
    case (size_i)
      SZ_B: begin
        load_data_c = {{24{~unsigned_i & lane_data[7]}}, lane_data[7:0]};
        mask        = 32'h0000_00FF << shamt;
      end
      SZ_H: begin
        load_data_c = {{16{~unsigned_i & lane_data[15]}}, lane_data[15:0]};
        mask        = 32'h0000_FFFF << shamt;
      end
      default: ;
    endcase
    merge_data_c = (old_i & ~mask) | ((wdata_i << shamt) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit in front of a word-addressed memory; sub-word stores via RMW.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic [2:0]                req_funct3,
  input  logic [XLEN-1:0]           req_addr,
  input  logic [XLEN-1:0]           req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [XLEN-1:0]           resp_rdata,
  output logic                      resp_fault,
  output logic [XLEN-1:0]           mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  output logic                      mem_rw,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata
);

  logic [2:0]                state_q, state_d;
  logic [XLEN-1:0]           addr_q, addr_d;
  logic [2:0]                funct3_q, funct3_d;
  logic                      store_q, store_d;
  logic [XLEN-1:0]           wdata_q, wdata_d;
  logic [MEM_DATA_WIDTH-1:0] old_q, old_d;
  logic                      req_ready_q, req_ready_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]           resp_rdata_q, resp_rdata_d;
  logic                      resp_fault_q, resp_fault_d;
  logic [XLEN-1:0]           mem_addr_q, mem_addr_d;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                      mem_rw_q, mem_rw_d;

  lsu_size_t                 size_c;
  logic                      req_fault_c;
  logic [MEM_DATA_WIDTH-1:0] load_data_c;
  logic [MEM_DATA_WIDTH-1:0] merge_data_c;

  // Decode of the registered op and fault screening of the incoming request
  always_comb begin
    size_c      = f3_size(funct3_q);
    req_fault_c = f3_illegal(req_store, req_funct3) ||
                  f3_misaligned(f3_size(req_funct3), req_addr[1:0]);
  end

  load_store_unit_align u_align (
    .size_i       (size_c),
    .unsigned_i   (funct3_q[2]),
    .lane_i       (addr_q[1:0]),
    .rdata_i      (mem_rdata),
    .wdata_i      (wdata_q),
    .old_i        (old_q),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    store_d      = store_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    mem_rw_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          store_d  = req_store;
          wdata_d  = req_wdata;
          if (req_fault_c) begin
            // Faulting requests never reach the memory port
            resp_rdata_d = '0;
            resp_fault_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            mem_addr_d = {2'b00, req_addr[XLEN-1:2]};
            state_d    = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!store_q) begin
          resp_rdata_d = load_data_c;
          resp_fault_d = 1'b0;
          state_d      = ST_RESP;
        end else if (size_c == SZ_W) begin
          mem_wdata_d = wdata_q;
          state_d     = ST_WRITE;
        end else begin
          old_d   = mem_rdata;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        mem_wdata_d = merge_data_c;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        resp_rdata_d = '0;
        resp_fault_d = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_rdata_d = '0;
          resp_fault_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake and strobe outputs follow the state being entered
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    mem_rw_d     = (state_d == ST_WRITE);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      store_q      <= 1'b0;
      wdata_q      <= '0;
      old_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rw_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      store_q      <= store_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rw_q     <= mem_rw_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rw     = mem_rw_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned DEPTH = 2 ** MEM_ADDR_WIDTH;

  logic        clk, rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] wword;
    logic [31:0] waddr;
    logic        fault;
    int          lat;
    int          writes;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] wword;
    logic [31:0] waddr;
    logic        fault;
    logic        idle_ready;
    logic        idle_valid;
    int          lat;
    int          rw_cnt;
    int          rw_lat;
  } obs_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
  } op_t;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        bd_we, bd_clr;
  int          bd_idx;
  logic [31:0] bd_data;

  exp_t sb_q[$];
  op_t  stim_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write on the edge where mem_rw is high
  assign mem_rdata = mem[mem_addr[MEM_ADDR_WIDTH-1:0]];
  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (mem_rw) begin
      mem[mem_addr[MEM_ADDR_WIDTH-1:0]] <= mem_wdata;
    end
  end

  task automatic preload(input int idx, input logic [31:0] data);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Reference model: expected response, latency and memory update
  task automatic ref_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output exp_t e);
    int          idx, nbytes, off;
    logic [31:0] w, v;
    e.rdata = '0; e.wword = '0; e.waddr = '0; e.fault = 1'b0; e.lat = 1; e.writes = 0;
    idx = int'(a[MEM_ADDR_WIDTH+1:2]);
    off = int'(a[1:0]);
    if (st) begin
      case (f3)
        3'd0: nbytes = 1; 3'd1: nbytes = 2; 3'd2: nbytes = 4; default: nbytes = 0;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: nbytes = 1; 3'd1, 3'd5: nbytes = 2; 3'd2: nbytes = 4; default: nbytes = 0;
      endcase
    end
    if (nbytes == 0 || (nbytes == 2 && a[0]) || (nbytes == 4 && a[1:0] != 2'b00)) begin
      e.fault = 1'b1;
      return;
    end
    w = ref_mem[idx];
    if (st) begin
      for (int b = 0; b < nbytes; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
      ref_mem[idx] = w;
      e.wword  = w;
      e.waddr  = {2'b00, a[31:2]};
      e.writes = 1;
      e.lat    = (nbytes == 4) ? 3 : 4;
    end else begin
      v = w >> (8 * off);
      if (nbytes == 1)      e.rdata = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      else if (nbytes == 2) e.rdata = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else                  e.rdata = v;
      e.lat = 2;
    end
  endtask

  // Drive one request (resp_ready high) and observe it through to the idle cycle
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output obs_t o);
    int guard = 0;
    o.rdata = '0; o.wword = '0; o.waddr = '0; o.fault = 1'b0;
    o.idle_ready = 1'b0; o.idle_valid = 1'b1; o.lat = 0; o.rw_cnt = 0; o.rw_lat = 0;
    while (req_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o.lat = 1;
    while (resp_valid !== 1'b1 && o.lat < 20) begin
      if (mem_rw === 1'b1) begin
        o.rw_cnt++; o.rw_lat = o.lat; o.wword = mem_wdata; o.waddr = mem_addr;
      end
      @(posedge clk); #1;
      o.lat++;
    end
    if (resp_valid !== 1'b1) o.lat = 99;
    if (mem_rw === 1'b1) o.rw_cnt++;
    o.rdata = resp_rdata;
    o.fault = resp_fault;
    @(posedge clk); #1;
    o.idle_ready = req_ready;
    o.idle_valid = resp_valid;
  endtask

  task automatic push_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    op_t op;
    op.st = st; op.f3 = f3; op.addr = a; op.wd = wd;
    stim_q.push_back(op);
  endtask

  // Run queued ops back to back, scoring each response against the model
  task automatic run_ops(input string name);
    op_t  op;
    exp_t e;
    obs_t o;
    while (stim_q.size() > 0) begin
      op = stim_q.pop_front();
      ref_access(op.st, op.f3, op.addr, op.wd, e);
      sb_q.push_back(e);
      do_req(op.st, op.f3, op.addr, op.wd, o);
      e = sb_q.pop_front();
      n_checks++; if (o.lat !== e.lat) $display("FAIL %s latency a=%h got %0d want %0d", name, op.addr, o.lat, e.lat); else n_pass++;
      n_checks++; if (o.rdata !== e.rdata) $display("FAIL %s rdata a=%h got %h want %h", name, op.addr, o.rdata, e.rdata); else n_pass++;
      n_checks++; if (o.fault !== e.fault) $display("FAIL %s fault a=%h got %b want %b", name, op.addr, o.fault, e.fault); else n_pass++;
      n_checks++; if (o.rw_cnt !== e.writes) $display("FAIL %s mem_rw cycles a=%h got %0d want %0d", name, op.addr, o.rw_cnt, e.writes); else n_pass++;
      if (e.writes == 1) begin
        n_checks++; if (o.wword !== e.wword) $display("FAIL %s mem_wdata a=%h got %h want %h", name, op.addr, o.wword, e.wword); else n_pass++;
        n_checks++; if (o.waddr !== e.waddr) $display("FAIL %s mem_addr a=%h got %h want %h", name, op.addr, o.waddr, e.waddr); else n_pass++;
        n_checks++; if (o.rw_lat !== e.lat - 1) $display("FAIL %s mem_rw cycle a=%h got %0d want %0d", name, op.addr, o.rw_lat, e.lat - 1); else n_pass++;
      end
      n_checks++; if ({o.idle_ready, o.idle_valid} !== 2'b10) $display("FAIL %s idle after resp got ready/valid=%b want 10", name, {o.idle_ready, o.idle_valid}); else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bd_clr = 1'b1; bd_we = 1'b0; bd_idx = 0; bd_data = '0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    bd_clr = 1'b0;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset req_ready got %b want 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset resp_valid got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_fault !== 1'b0) $display("FAIL reset resp_fault got %b want 0", resp_fault); else n_pass++;
    n_checks++; if (resp_rdata !== 32'h0) $display("FAIL reset resp_rdata got %h want 0", resp_rdata); else n_pass++;
    n_checks++; if (mem_rw !== 1'b0) $display("FAIL reset mem_rw got %b want 0", mem_rw); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset mem_addr got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h0) $display("FAIL reset mem_wdata got %h want 0", mem_wdata); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    push_op(1'b1, F3_SW, 32'h10, 32'hDEADBEEF);
    push_op(1'b0, F3_LW, 32'h10, 32'h0);
    run_ops("word");
    n_checks++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL word mem[4] got %h want deadbeef", mem[4]); else n_pass++;
  endtask

  task automatic test_sub_word();
    preload(4, 32'h11223344);
    push_op(1'b1, F3_SB,  32'h13, 32'h000000A5);
    push_op(1'b0, F3_LB,  32'h13, 32'h0);
    push_op(1'b0, F3_LBU, 32'h13, 32'h0);
    run_ops("byte");
    n_checks++; if (mem[4] !== 32'hA5223344) $display("FAIL byte mem[4] got %h want a5223344", mem[4]); else n_pass++;
    preload(4, 32'h0);
    push_op(1'b1, F3_SH,  32'h12, 32'h00008001);
    push_op(1'b0, F3_LH,  32'h12, 32'h0);
    push_op(1'b0, F3_LHU, 32'h12, 32'h0);
    run_ops("half");
    n_checks++; if (mem[4] !== 32'h80010000) $display("FAIL half mem[4] got %h want 80010000", mem[4]); else n_pass++;
  endtask

  task automatic test_fault();
    push_op(1'b0, F3_LW,  32'h02, 32'h0);
    push_op(1'b1, F3_SH,  32'h01, 32'h1234);
    push_op(1'b0, 3'b011, 32'h10, 32'h0);
    push_op(1'b0, 3'b110, 32'h10, 32'h0);
    push_op(1'b0, 3'b111, 32'h10, 32'h0);
    push_op(1'b1, 3'b100, 32'h10, 32'hFFFF);
    push_op(1'b0, F3_LHU, 32'h13, 32'h0);
    push_op(1'b1, F3_SW,  32'h16, 32'h55);
    run_ops("fault");
    n_checks++; if (mem[4] !== 32'h80010000) $display("FAIL fault memory touched got %h want 80010000", mem[4]); else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   guard = 0;
    preload(5, 32'hCAFEF00D);
    preload(6, 32'h0BADBEEF);
    ref_access(1'b0, F3_LW, 32'h14, 32'h0, e);
    sb_q.push_back(e);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_LW; req_addr = 32'h14; req_wdata = '0;
    @(posedge clk); #1;
    // Keep a store request presented while the unit is busy: it must be ignored
    req_store = 1'b1; req_funct3 = F3_SW; req_addr = 32'h18; req_wdata = 32'h12345678;
    while (resp_valid !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata) $display("FAIL stall hold cyc%0d got valid=%b rdata=%h want 1 %h", i, resp_valid, resp_rdata, e.rdata); else n_pass++;
      n_checks++; if (req_ready !== 1'b0 || mem_rw !== 1'b0) $display("FAIL stall busy cyc%0d got ready=%b rw=%b want 0 0", i, req_ready, mem_rw); else n_pass++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL stall release got ready/valid=%b want 10", {req_ready, resp_valid}); else n_pass++;
    n_checks++; if (mem[6] !== 32'h0BADBEEF) $display("FAIL stall ignored store got %h want 0badbeef", mem[6]); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int   rw_seen = 0;
    preload(8, 32'h55667788);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_SB; req_addr = 32'h21; req_wdata = 32'hEE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (mem_rw === 1'b1) rw_seen++;
    @(posedge clk); #1;
    if (mem_rw === 1'b1) rw_seen++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (mem_rw === 1'b1) rw_seen++;
    n_checks++; if (rw_seen !== 0) $display("FAIL rst_merge mem_rw cycles got %0d want 0", rw_seen); else n_pass++;
    n_checks++; if (mem[8] !== 32'h55667788) $display("FAIL rst_merge memory got %h want 55667788", mem[8]); else n_pass++;
    n_checks++; if ({req_ready, resp_valid, resp_fault} !== 3'b100) $display("FAIL rst_merge handshake got %b want 100", {req_ready, resp_valid, resp_fault}); else n_pass++;
    n_checks++; if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) $display("FAIL rst_merge data outs got %h %h %h want 0", resp_rdata, mem_addr, mem_wdata); else n_pass++;
    @(posedge clk); #1;
    ref_access(1'b1, F3_SW, 32'h24, 32'h600DCAFE, e);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_SW; req_addr = 32'h24; req_wdata = 32'h600DCAFE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (mem_rw !== 1'b1) $display("FAIL rst_write strobe got %b want 1", mem_rw); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (mem[9] !== e.wword) $display("FAIL rst_write commit got %h want %h", mem[9], e.wword); else n_pass++;
    n_checks++; if ({req_ready, resp_valid, mem_rw} !== 3'b100) $display("FAIL rst_write idle got %b want 100", {req_ready, resp_valid, mem_rw}); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic        st;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = F3_LHU;
      end
      a = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      push_op(st, f3, a, $urandom());
    end
    run_ops("b2b");
  endtask

  initial begin
    test_reset();
    test_word();
    test_sub_word();
    test_fault();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
